// File: rtl/frotaegis_pkg.sv
// Shared types and helpers for the Frotaegis capture buffer.
// The optional drop counter is enabled with FROTAEGIS_DROP_CNT_EN.
package frotaegis_pkg;

  typedef enum logic {
    FILL = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int entry_width(input int ch_size, input int data_size);
    return ch_size + data_size;
  endfunction

  // Supports up to 32 channels; callers zero-extend their valid vector.
  function automatic logic [DROP_CNT_W-1:0] popcount(input logic [31:0] v);
    logic [DROP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + DROP_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/frotaegis_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest-index request at or
// after ptr, wrapping at CH_NUM. ptr must be below CH_NUM.
module frotaegis_rr_arbiter
  import frotaegis_pkg::*;
#(
  parameter int CH_NUM  = 2,
  parameter int CH_SIZE = 1
) (
  input  logic [CH_NUM-1:0]  req,
  input  logic [CH_SIZE-1:0] ptr,
  output logic [CH_NUM-1:0]  grant,
  output logic [CH_SIZE-1:0] idx,
  output logic               any
);

  always_comb begin
    int c;
    logic [CH_SIZE-1:0] ci;
    c     = 0;
    ci    = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      c = int'(ptr) + k;
      if (c >= CH_NUM) c = c - CH_NUM;
      ci = CH_SIZE'(c);
      if (!any && req[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/frotaegis_capture_buffer.sv
// Multi-channel capture buffer: round-robin merge into a circular history,
// freeze after DATA_NUM writes, oldest-first readout. Option: FROTAEGIS_DROP_CNT_EN.
module frotaegis_capture_buffer
  import frotaegis_pkg::*;
#(
  parameter int DATA_SIZE   = 4,
  parameter int CH_NUM      = 2,
  parameter int CH_SIZE     = 1,
  parameter int DATA_NUM    = 16,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CH_NUM-1:0]             valid,
  input  logic [CH_NUM*DATA_SIZE-1:0]   data,
  input  logic                          coll,
  output logic                          stop4calc,
  input  logic                          rd_en,
  output logic [CH_SIZE+DATA_SIZE-1:0]  rd_data,
  output logic                          rd_valid,
  input  logic                          calc_done,
  output logic [LENGTH_SIZE:0]          level
`ifdef FROTAEGIS_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]         drop_cnt
`endif
);

  localparam int ENTRY_W = entry_width(CH_SIZE, DATA_SIZE);
  localparam logic [LENGTH_SIZE:0] LEVEL_FULL = (LENGTH_SIZE + 1)'(LENGTH);
  localparam logic [LENGTH_SIZE:0] WIN_LAST   = (LENGTH_SIZE + 1)'(DATA_NUM);
  localparam logic [CH_SIZE-1:0]   CH_LAST    = CH_SIZE'(CH_NUM - 1);

  state_t                 state_reg, state_next;
  logic [LENGTH_SIZE:0]   win_cnt_reg, win_cnt_next;
  logic [LENGTH_SIZE:0]   level_reg;
  logic [LENGTH_SIZE-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CH_SIZE-1:0]     rr_ptr_reg;
  logic [ENTRY_W-1:0]     rd_data_reg;
  logic                   rd_valid_reg;

  logic [CH_NUM-1:0]      grant;
  logic [CH_SIZE-1:0]     grant_idx;
  logic                   grant_any;
  logic [DATA_SIZE-1:0]   masked [CH_NUM];
  logic [DATA_SIZE-1:0]   sample;
  logic                   wr_en, pop, full;

  logic [ENTRY_W-1:0]     mem [LENGTH];

  frotaegis_rr_arbiter #(
    .CH_NUM  (CH_NUM),
    .CH_SIZE (CH_SIZE)
  ) u_arbiter (
    .req   (valid),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_mask
      assign masked[gi] = data[gi*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{grant[gi]}};
    end
  endgenerate

  always_comb begin
    sample = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      sample = sample | masked[i];
    end
  end

  assign full  = (level_reg == LEVEL_FULL);
  assign wr_en = (state_reg == FILL) && coll && grant_any;
  assign pop   = (state_reg == CALC) && rd_en && (level_reg != '0);

  always_comb begin
    state_next   = state_reg;
    win_cnt_next = win_cnt_reg;
    case (state_reg)
      FILL: begin
        if (wr_en) begin
          win_cnt_next = win_cnt_reg + 1'b1;
          if (win_cnt_next == WIN_LAST) state_next = CALC;
        end
      end
      CALC: begin
        if (calc_done) begin
          state_next   = FILL;
          win_cnt_next = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      win_cnt_reg  <= '0;
      level_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rr_ptr_reg   <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      win_cnt_reg  <= win_cnt_next;
      rd_valid_reg <= pop;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        rr_ptr_reg <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
        // A full buffer drops its oldest entry so the reader stays on the oldest survivor.
        if (full) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      end
      if (wr_en && !full) level_reg <= level_reg + 1'b1;
      else if (pop)       level_reg <= level_reg - 1'b1;
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {grant_idx, sample};
  end

  assign stop4calc = (state_reg == CALC);
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign level     = level_reg;

`ifdef FROTAEGIS_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic [DROP_CNT_W-1:0] drops;
  logic [DROP_CNT_W:0]   drop_sum;

  always_comb begin
    drops = '0;
    if (coll) begin
      drops = popcount(32'(valid));
      if ((state_reg == FILL) && grant_any) drops = drops - 1'b1;
    end
  end

  assign drop_sum = {1'b0, drop_cnt_reg} + {1'b0, drops};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if ((state_reg == CALC) && calc_done) begin
      drop_cnt_reg <= '0;
    end else if (drop_sum[DROP_CNT_W]) begin
      drop_cnt_reg <= '1;
    end else begin
      drop_cnt_reg <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_frotaegis_capture_buffer.sv
// Self-checking bench for frotaegis_capture_buffer against a queue-based model.
module tb_frotaegis_capture_buffer;

  localparam int DATA_SIZE   = 4;
  localparam int CH_NUM      = 2;
  localparam int CH_SIZE     = 1;
  localparam int DATA_NUM    = 16;
  localparam int LENGTH      = 64;
  localparam int LENGTH_SIZE = 6;
  localparam int ENTRY_W     = CH_SIZE + DATA_SIZE;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [CH_NUM-1:0]           valid;
  logic [CH_NUM*DATA_SIZE-1:0] data;
  logic                        coll;
  logic                        stop4calc;
  logic                        rd_en;
  logic [ENTRY_W-1:0]          rd_data;
  logic                        rd_valid;
  logic                        calc_done;
  logic [LENGTH_SIZE:0]        level;
`ifdef FROTAEGIS_DROP_CNT_EN
  logic [15:0]                 drop_cnt;
`endif

  frotaegis_capture_buffer #(
    .DATA_SIZE(DATA_SIZE), .CH_NUM(CH_NUM), .CH_SIZE(CH_SIZE),
    .DATA_NUM(DATA_NUM), .LENGTH(LENGTH), .LENGTH_SIZE(LENGTH_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .coll(coll),
    .stop4calc(stop4calc), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .calc_done(calc_done), .level(level)
`ifdef FROTAEGIS_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: history as a bounded queue, oldest at the front.
  logic [ENTRY_W-1:0] m_q[$];
  int                 m_calc, m_win, m_rr, m_drop;
  logic [ENTRY_W-1:0] m_rd;
  bit                 m_rv;

  function automatic void model_reset();
    m_q.delete();
    m_calc = 0; m_win = 0; m_rr = 0; m_drop = 0;
    m_rd = '0; m_rv = 0;
  endfunction

  function automatic void model_step(input logic [CH_NUM-1:0] v, input logic [CH_NUM*DATA_SIZE-1:0] d,
                                     input logic c, input logic re, input logic cd);
    int nv, g, ch;
    nv = 0; g = -1;
    for (int i = 0; i < CH_NUM; i++) nv += int'(v[i]);
    m_rv = 0;
    if (m_calc == 0) begin
      if (c && nv > 0) begin
        for (int k = 0; k < CH_NUM; k++) begin
          ch = (m_rr + k) % CH_NUM;
          if (g < 0 && v[ch]) g = ch;
        end
        m_q.push_back({g[CH_SIZE-1:0], d[g*DATA_SIZE +: DATA_SIZE]});
        if (m_q.size() > LENGTH) void'(m_q.pop_front());
        m_rr = (g + 1) % CH_NUM;
        m_win++;
        if (m_win == DATA_NUM) m_calc = 1;
        m_drop += nv - 1;
      end
    end else begin
      if (c) m_drop += nv;
      if (re && m_q.size() > 0) begin
        m_rd = m_q.pop_front();
        m_rv = 1;
      end
      if (cd) begin
        m_calc = 0; m_win = 0; m_drop = 0;
      end
    end
    if (m_drop > 65535) m_drop = 65535;
  endfunction

  // Drive one clock cycle: inputs set before the edge, return 1 time unit after it.
  task automatic cycle(input logic [CH_NUM-1:0] v, input logic [CH_NUM*DATA_SIZE-1:0] d,
                       input logic c, input logic re, input logic cd);
    valid = v; data = d; coll = c; rd_en = re; calc_done = cd;
    model_step(v, d, c, re, cd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '0; data = '0; coll = 1'b0; rd_en = 1'b0; calc_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (stop4calc !== 1'b0) begin n_fail++; $display("FAIL reset_stop4calc: got %0b expected 0", stop4calc); end
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_single_channel();
    for (int i = 0; i < DATA_NUM; i++) begin
      cycle(2'b01, {4'h0, 4'(i)}, 1'b1, 1'b0, 1'b0);
      n_tests++; if (stop4calc !== (i == DATA_NUM - 1)) begin n_fail++; $display("FAIL single_stop4calc[%0d]: got %0b expected %0b", i, stop4calc, i == DATA_NUM - 1); end
      n_tests++; if (level !== 7'(i + 1)) begin n_fail++; $display("FAIL single_level[%0d]: got %0d expected %0d", i, level, i + 1); end
    end
    for (int i = 0; i < DATA_NUM; i++) begin
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid[%0d]: got %0b expected 1", i, rd_valid); end
      n_tests++; if (rd_data !== {1'b0, 4'(i)}) begin n_fail++; $display("FAIL single_rd_data[%0d]: got %h expected %h", i, rd_data, {1'b0, 4'(i)}); end
      n_tests++; if (level !== 7'(DATA_NUM - 1 - i)) begin n_fail++; $display("FAIL single_rd_level[%0d]: got %0d expected %0d", i, level, DATA_NUM - 1 - i); end
    end
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (stop4calc !== 1'b0) begin n_fail++; $display("FAIL single_rearm: got %0b expected 0", stop4calc); end
    $display("[TB] single channel window done");
  endtask

  task automatic test_two_channels();
    int cnt0, cnt1, prev_tag;
    cnt0 = 0; cnt1 = 0; prev_tag = -1;
    for (int i = 0; i < DATA_NUM; i++) cycle(2'b11, {4'hA, 4'h3}, 1'b1, 1'b0, 1'b0);
    n_tests++; if (stop4calc !== 1'b1) begin n_fail++; $display("FAIL two_stop4calc: got %0b expected 1", stop4calc); end
`ifdef FROTAEGIS_DROP_CNT_EN
    n_tests++; if (drop_cnt !== 16'd16) begin n_fail++; $display("FAIL two_drop_cnt: got %0d expected 16", drop_cnt); end
`endif
    for (int i = 0; i < DATA_NUM; i++) begin
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin n_fail++; $display("FAIL two_rd[%0d]: got v=%0b %h expected v=1 %h", i, rd_valid, rd_data, m_rd); end
      n_tests++; if (int'(rd_data[4]) == prev_tag || rd_data[3:0] !== (rd_data[4] ? 4'hA : 4'h3)) begin n_fail++; $display("FAIL two_alternate[%0d]: got %h after tag %0d", i, rd_data, prev_tag); end
      prev_tag = int'(rd_data[4]);
      if (rd_data[4]) cnt1++; else cnt0++;
    end
    n_tests++; if (cnt0 != 8 || cnt1 != 8) begin n_fail++; $display("FAIL two_per_channel: got %0d/%0d expected 8/8", cnt0, cnt1); end
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    $display("[TB] two channel window done");
  endtask

  task automatic test_full_history();
    test_reset();
    for (int w = 0; w < LENGTH / DATA_NUM; w++) begin
      for (int i = 0; i < DATA_NUM; i++)
        cycle(2'($urandom_range(1, 3)), 8'($urandom), 1'b1, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b0, 1'b1);
    end
    n_tests++; if (level !== 7'(LENGTH)) begin n_fail++; $display("FAIL full_level: got %0d expected %0d", level, LENGTH); end
    for (int i = 0; i < DATA_NUM; i++) begin
      cycle(2'($urandom_range(1, 3)), 8'h55, 1'b1, 1'b0, 1'b0);
      n_tests++; if (level !== 7'(LENGTH)) begin n_fail++; $display("FAIL full_overwrite_level[%0d]: got %0d expected %0d", i, level, LENGTH); end
    end
    n_tests++; if (stop4calc !== 1'b1) begin n_fail++; $display("FAIL full_stop4calc: got %0b expected 1", stop4calc); end
    for (int i = 0; i < LENGTH; i++) begin
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin n_fail++; $display("FAIL full_rd[%0d]: got v=%0b %h expected v=1 %h", i, rd_valid, rd_data, m_rd); end
      if (i >= LENGTH - DATA_NUM) begin
        n_tests++; if (rd_data[3:0] !== 4'h5) begin n_fail++; $display("FAIL full_newest[%0d]: got %h expected 5", i, rd_data[3:0]); end
      end
    end
    $display("[TB] full history done");
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 8; i++) begin
      cycle(2'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rd_valid[%0d]: got %0b expected 0", i, rd_valid); end
      n_tests++; if (level !== '0 || stop4calc !== 1'b1) begin n_fail++; $display("FAIL empty_state[%0d]: got level=%0d stop=%0b expected 0/1", i, level, stop4calc); end
    end
    $display("[TB] empty read done");
  endtask

  task automatic test_calc_done_pop();
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DATA_NUM; i++) cycle(2'($urandom_range(1, 3)), 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin n_fail++; $display("FAIL cdpop_rd[%0d]: got v=%0b %h expected v=1 %h", i, rd_valid, rd_data, m_rd); end
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin n_fail++; $display("FAIL cdpop_last: got v=%0b %h expected v=1 %h", rd_valid, rd_data, m_rd); end
    n_tests++; if (stop4calc !== 1'b0 || level !== 7'd12) begin n_fail++; $display("FAIL cdpop_state: got stop=%0b level=%0d expected 0/12", stop4calc, level); end
    cycle(2'b01, 8'h07, 1'b1, 1'b0, 1'b0);
    n_tests++; if (level !== 7'd13 || stop4calc !== 1'b0) begin n_fail++; $display("FAIL cdpop_resume: got level=%0d stop=%0b expected 13/0", level, stop4calc); end
    $display("[TB] calc_done with pop done");
  endtask

  task automatic test_reset_mid();
    logic [ENTRY_W-1:0] first;
    int guard;
    guard = 0;
    while (stop4calc !== 1'b1 && guard < 100) begin
      cycle(2'($urandom_range(1, 3)), 8'($urandom), 1'b1, 1'b0, 1'b0);
      guard++;
    end
    n_tests++; if (stop4calc !== 1'b1) begin n_fail++; $display("FAIL mid_reach_calc: got %0b expected 1", stop4calc); end
    while (m_q.size() > 9 && guard < 200) begin
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    n_tests++; if (level !== 7'd9 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: got level=%0d v=%0b expected 9/1", level, rd_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (level !== '0 || stop4calc !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_reset: got level=%0d stop=%0b v=%0b expected 0/0/0", level, stop4calc, rd_valid); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    first = {1'b0, 4'hC};
    cycle(2'b01, 8'h0C, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < DATA_NUM; i++) cycle(2'b11, 8'($urandom), 1'b1, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== first) begin n_fail++; $display("FAIL mid_first_entry: got v=%0b %h expected v=1 %h", rd_valid, rd_data, first); end
    $display("[TB] mid-readout reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle(2'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0);
      n_tests++; if (stop4calc !== 1'(m_calc)) begin n_fail++; $display("FAIL rand_stop4calc[%0d]: got %0b expected %0d", i, stop4calc, m_calc); end
      n_tests++; if (level !== 7'(m_q.size())) begin n_fail++; $display("FAIL rand_level[%0d]: got %0d expected %0d", i, level, m_q.size()); end
      n_tests++; if (rd_valid !== m_rv) begin n_fail++; $display("FAIL rand_rd_valid[%0d]: got %0b expected %0b", i, rd_valid, m_rv); end
      if (m_rv) begin
        n_tests++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", i, rd_data, m_rd); end
      end
`ifdef FROTAEGIS_DROP_CNT_EN
      n_tests++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rand_drop_cnt[%0d]: got %0d expected %0d", i, drop_cnt, m_drop); end
`endif
    end
    $display("[TB] random traffic done");
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_two_channels();
    test_full_history();
    test_empty_read();
    test_calc_done_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
